pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Parametrised program sequencer; successor to the 6-bit program counter.
//  Generates the instruction-memory address each cycle: increment, absolute jump,
//  signed relative branch, subroutine call/return via a hardware return stack, stall.
//  Sits between the instruction decoder (Op/AddrIn) and instruction-memory address port.
// PARAMETERS
//  ADDR_W      6   address width in bits (AddrIn, AddrOut, stack entries)
//  STACK_DEPTH 4   return-stack entries (>=1); pointer width $clog2(STACK_DEPTH+1)
//  RESET_ADDR  0   AddrOut value while nReset is low and on release
// PORTS
//  clk        in   1       single clock, all state on posedge
//  nReset     in   1       asynchronous, active-low reset
//  Stall      in   1       1 = hold all state this cycle, Op ignored
//  Op         in   3       pc_op_t command, sampled on posedge when Stall=0
//  AddrIn     in   ADDR_W  JUMP/CALL target, or BRANCH signed offset
//  AddrOut    out  ADDR_W  current program address (registered)
//  StackEmpty out  1       return stack holds 0 entries
//  StackFull  out  1       return stack holds STACK_DEPTH entries
//  StackErr   out  1       sticky: overflow or underflow occurred since reset
// BEHAVIOUR
//  - Clock: one clk, all state on posedge. Reset: nReset async, active-low.
//  - Reset (async assert, sync release): AddrOut=RESET_ADDR, stack ptr=0,
//    StackEmpty=1, StackFull=0, StackErr=0. Mid-operation reset discards stack contents.
//  - Latency: Op/AddrIn sampled at edge N; new AddrOut valid after edge N.
//  - Stall=1: AddrOut, stack, flags all hold; takes priority over every Op.
//  - Op (Stall=0), N = AddrOut + 1 mod 2^ADDR_W:
//    NOP    AddrOut <= N (wraps all-ones -> 0)
//    JUMP   AddrOut <= AddrIn (AddrIn=0 is a normal jump, no special case)
//    BRANCH AddrOut <= AddrOut + $signed(AddrIn), ADDR_W-bit two's-complement wrap
//    CALL   not full: push N, AddrOut <= AddrIn; full: no push, StackErr<=1, AddrOut <= N
//    RET    not empty: pop, AddrOut <= popped entry; empty: StackErr<=1, AddrOut <= N
//    other encodings: treated as NOP
//  - Stack is LIFO; push writes entry[ptr], ptr++; pop reads entry[ptr-1], ptr--.
//  - StackEmpty/StackFull are combinational from ptr (registered state), reflect
//    post-edge ptr. StackErr clears only on reset.
//  - No combinational path from Op/AddrIn/Stall to any output.
// CONFIGURATION
//  - Macro PC_SEQ_STACK_EN.
//  - Defined: return stack, CALL/RET and stack flags as above.
//  - Undefined: no stack storage; CALL behaves as JUMP, RET behaves as NOP;
//    StackEmpty tied 1, StackFull tied 0, StackErr tied 0.
// STRUCTURE
//  - Shared package uproc_pkg: typedef enum logic [2:0] pc_op_t
//    {PC_NOP=0, PC_JUMP=1, PC_BRANCH=2, PC_CALL=3, PC_RET=4}; reused by decoder.
//  - Sub-module pc_return_stack (ADDR_W, STACK_DEPTH): push/pop/data/ptr/full/empty;
//    instantiated only under PC_SEQ_STACK_EN. Next-address mux and error flag in top.
// TESTING
//  - Reset: nReset low mid-count at AddrOut=0x15 -> AddrOut=0 immediately (no clk edge),
//    flags 1/0/0; release, 3x NOP -> 1,2,3.
//  - Wrap/stall: run to 0x3F, NOP -> 0x00; Stall=1 with Op=JUMP 0x20 for 2 cycles ->
//    AddrOut holds; Stall=0 -> 0x20.
//  - Branch: AddrOut=0x10, BRANCH 0x3E (-2) -> 0x0E; at 0x3E BRANCH 0x05 -> 0x03.
//  - Nested call: at 0x04 CALL 0x20, at 0x20 CALL 0x30 -> ptr=2; RET -> 0x21, RET -> 0x05,
//    StackEmpty=1, StackErr=0.
//  - Overflow/underflow: 4 CALLs -> StackFull=1; 5th CALL at A -> AddrOut=A+1, StackErr=1;
//    after reset, RET at 0x07 -> 0x08, StackErr=1, stays 1 through later NOPs.
//  - Macro off: CALL 0x20 -> 0x20, RET -> 0x21; StackErr stays 0.

Source files
------------

// File: rtl/uproc_pkg.sv
// Shared micro-processor definitions used by the program sequencer and the decoder.
// Holds the sequencer command encoding so both sides agree on one enum.
// No logic lives here, only types and constants.
package uproc_pkg;

  localparam int PC_OP_W = 3;

  // Sequencer commands issued by the instruction decoder.
  // Encodings 5..7 are unused and are treated as PC_NOP.
  typedef enum logic [PC_OP_W-1:0] {
    PC_NOP    = 3'd0,
    PC_JUMP   = 3'd1,
    PC_BRANCH = 3'd2,
    PC_CALL   = 3'd3,
    PC_RET    = 3'd4
  } pc_op_t;

endpackage

// File: rtl/pc_return_stack.sv
// LIFO return-address stack for subroutine CALL/RET.
// Latency: push/pop take effect on the posedge; pop_data/ptr/full/empty are read combinationally.
// Backpressure: none; push while full and pop while empty are ignored (the caller flags the error).
module pc_return_stack #(
  parameter int ADDR_W      = 6,
  parameter int STACK_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               nReset,
  input  logic                               push,
  input  logic                               pop,
  input  logic [ADDR_W-1:0]                  push_data,
  output logic [ADDR_W-1:0]                  pop_data,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   ptr,
  output logic                               full,
  output logic                               empty
);

  localparam int PTR_W = $clog2(STACK_DEPTH+1);

  logic [PTR_W-1:0]  ptr_q;
  logic [ADDR_W-1:0] mem [STACK_DEPTH];

  assign ptr   = ptr_q;
  assign full  = (ptr_q == PTR_W'(STACK_DEPTH));
  assign empty = (ptr_q == '0);

  // Stack pointer: counts occupied entries; contents are abandoned on reset.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      ptr_q <= '0;
    end else if (push && !full) begin
      ptr_q <= ptr_q + 1'b1;
    end else if (pop && !empty) begin
      ptr_q <= ptr_q - 1'b1;
    end
  end

  // Entry storage: a push writes the slot the pointer currently addresses.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (push && !full && (ptr_q == PTR_W'(i))) begin
        mem[i] <= push_data;
      end
    end
  end

  // Top-of-stack read: entry[ptr-1], zero when empty.
  always_comb begin
    pop_data = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (ptr_q == PTR_W'(i + 1)) begin
        pop_data = mem[i];
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program sequencer: next instruction address via increment/jump/branch/call/return, with stall.
// Latency: Op/AddrIn sampled at a posedge, AddrOut registered and valid right after it.
// Backpressure: Stall=1 freezes address, stack and flags; PC_SEQ_STACK_EN enables the return stack.
module pc_sequencer
  import uproc_pkg::*;
#(
  parameter int              ADDR_W      = 6,
  parameter int              STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              Stall,
  input  pc_op_t            Op,
  input  logic [ADDR_W-1:0] AddrIn,
  output logic [ADDR_W-1:0] AddrOut,
  output logic              StackEmpty,
  output logic              StackFull,
  output logic              StackErr
);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] addr_inc;

  // Sequential successor, wraps naturally at 2^ADDR_W.
  assign addr_inc = addr_q + 1'b1;
  assign AddrOut  = addr_q;

`ifdef PC_SEQ_STACK_EN
  localparam int PTR_W = $clog2(STACK_DEPTH+1);

  logic              stk_push;
  logic              stk_pop;
  logic [ADDR_W-1:0] stk_pop_data;
  logic [PTR_W-1:0]  stk_ptr;
  logic              stk_full;
  logic              stk_empty;
  logic              err_q;
  logic              err_set;

  pc_return_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .nReset    (nReset),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (addr_inc),
    .pop_data  (stk_pop_data),
    .ptr       (stk_ptr),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  // Flags come straight from the registered pointer, so they show the post-edge depth.
  assign StackEmpty = (stk_ptr == '0);
  assign StackFull  = (stk_ptr == PTR_W'(STACK_DEPTH));
  assign StackErr   = err_q;

  // Next-address mux; stack overflow/underflow fall through to the sequential address.
  always_comb begin
    addr_d   = addr_q;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    err_set  = 1'b0;
    if (!Stall) begin
      case (Op)
        PC_JUMP:   addr_d = AddrIn;
        PC_BRANCH: addr_d = addr_q + AddrIn;
        PC_CALL: begin
          if (stk_full) begin
            err_set = 1'b1;
            addr_d  = addr_inc;
          end else begin
            stk_push = 1'b1;
            addr_d   = AddrIn;
          end
        end
        PC_RET: begin
          if (stk_empty) begin
            err_set = 1'b1;
            addr_d  = addr_inc;
          end else begin
            stk_pop = 1'b1;
            addr_d  = stk_pop_data;
          end
        end
        default:   addr_d = addr_inc;
      endcase
    end
  end

  // Sticky stack error, cleared only by reset.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end
`else
  // Without a return stack CALL is a plain jump and RET is a plain increment.
  assign StackEmpty = 1'b1;
  assign StackFull  = 1'b0;
  assign StackErr   = 1'b0;

  // Next-address mux for the stackless build.
  always_comb begin
    addr_d = addr_q;
    if (!Stall) begin
      case (Op)
        PC_JUMP:   addr_d = AddrIn;
        PC_CALL:   addr_d = AddrIn;
        PC_BRANCH: addr_d = addr_q + AddrIn;
        default:   addr_d = addr_inc;
      endcase
    end
  end
`endif

  // Program address register.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      addr_q <= RESET_ADDR;
    end else begin
      addr_q <= addr_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: vector table for increment/jump/branch/stall/wrap,
// hand sequences for reset, CALL/RET nesting, overflow and underflow.
// Build with or without PC_SEQ_STACK_EN; expectations follow the selected configuration.
module tb_pc_sequencer;
  import uproc_pkg::*;

  logic       clk;
  logic       nReset;
  logic       Stall;
  pc_op_t     Op;
  logic [5:0] AddrIn;
  logic [5:0] AddrOut;
  logic       StackEmpty;
  logic       StackFull;
  logic       StackErr;

  int tests;
  int fails;

  pc_sequencer #(
    .ADDR_W      (6),
    .STACK_DEPTH (4),
    .RESET_ADDR  (6'h00)
  ) dut (
    .clk        (clk),
    .nReset     (nReset),
    .Stall      (Stall),
    .Op         (Op),
    .AddrIn     (AddrIn),
    .AddrOut    (AddrOut),
    .StackEmpty (StackEmpty),
    .StackFull  (StackFull),
    .StackErr   (StackErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       stall;
    pc_op_t     op;
    logic [5:0] ain;
    logic [5:0] exp_addr;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // flags packed as {StackEmpty, StackFull, StackErr}
  task automatic chk_flags(input string name, input logic [2:0] exp);
    chk(name, {5'd0, StackEmpty, StackFull, StackErr}, {5'd0, exp});
  endtask

  // Drive one command, let one posedge pass, settle #1 after it.
  task automatic step(input logic st, input pc_op_t op, input logic [5:0] ain);
    Stall  = st;
    Op     = op;
    AddrIn = ain;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    nReset = 1'b0;
    #2;
    @(negedge clk);
    nReset = 1'b1;
    #1;
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    nReset = 1'b0;
    Stall  = 1'b0;
    Op     = PC_NOP;
    AddrIn = '0;

    vecs[0]  = '{1'b0, PC_JUMP,   6'h3E, 6'h3E};
    vecs[1]  = '{1'b0, PC_NOP,    6'h00, 6'h3F};
    vecs[2]  = '{1'b0, PC_NOP,    6'h00, 6'h00};  // wrap
    vecs[3]  = '{1'b0, PC_JUMP,   6'h10, 6'h10};
    vecs[4]  = '{1'b0, PC_BRANCH, 6'h3E, 6'h0E};  // -2
    vecs[5]  = '{1'b0, PC_JUMP,   6'h3E, 6'h3E};
    vecs[6]  = '{1'b0, PC_BRANCH, 6'h05, 6'h03};  // forward wrap
    vecs[7]  = '{1'b1, PC_JUMP,   6'h20, 6'h03};  // stalled
    vecs[8]  = '{1'b1, PC_JUMP,   6'h20, 6'h03};  // stalled
    vecs[9]  = '{1'b0, PC_JUMP,   6'h20, 6'h20};
    vecs[10] = '{1'b0, pc_op_t'(3'd7), 6'h11, 6'h21};
    vecs[11] = '{1'b0, pc_op_t'(3'd5), 6'h11, 6'h22};
    vecs[12] = '{1'b0, PC_JUMP,   6'h00, 6'h00};  // jump to zero is ordinary
    vecs[13] = '{1'b0, PC_BRANCH, 6'h00, 6'h00};
    vecs[14] = '{1'b0, PC_BRANCH, 6'h20, 6'h20};  // -32 from 0
    vecs[15] = '{1'b1, PC_NOP,    6'h00, 6'h20};
    vecs[16] = '{1'b0, PC_BRANCH, 6'h1F, 6'h3F};

    // Reset values while held
    #3;
    chk("reset_addr", {2'b0, AddrOut}, 8'h00);
    chk_flags("reset_flags", 3'b100);
    @(negedge clk);
    nReset = 1'b1;

    // Count to 0x15, then asynchronous reset mid-count
    @(negedge clk);
    step(1'b0, PC_JUMP, 6'h14);
    step(1'b0, PC_NOP, 6'h00);
    chk("pre_reset_addr", {2'b0, AddrOut}, 8'h15);
    #2;
    nReset = 1'b0;
    #1;
    chk("async_reset_addr", {2'b0, AddrOut}, 8'h00);
    chk_flags("async_reset_flags", 3'b100);
    @(negedge clk);
    nReset = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, PC_NOP, 6'h00);
      chk($sformatf("post_reset_nop%0d", i), {2'b0, AddrOut}, 8'(i));
    end

    // Vector table
    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].stall, vecs[i].op, vecs[i].ain);
      chk($sformatf("vec%0d_addr", i), {2'b0, AddrOut}, {2'b0, vecs[i].exp_addr});
      chk_flags($sformatf("vec%0d_flags", i), 3'b100);
    end

`ifdef PC_SEQ_STACK_EN
    // Nested call / return
    step(1'b0, PC_JUMP, 6'h04);
    step(1'b0, PC_CALL, 6'h20);
    chk("call1_addr", {2'b0, AddrOut}, 8'h20);
    chk_flags("call1_flags", 3'b000);
    step(1'b0, PC_CALL, 6'h30);
    chk("call2_addr", {2'b0, AddrOut}, 8'h30);
    chk("call2_ptr", {5'd0, dut.u_stack.ptr}, 8'd2);
    step(1'b1, PC_RET, 6'h00);
    chk("stall_ret_addr", {2'b0, AddrOut}, 8'h30);
    step(1'b0, PC_RET, 6'h00);
    chk("ret1_addr", {2'b0, AddrOut}, 8'h21);
    step(1'b0, PC_RET, 6'h00);
    chk("ret2_addr", {2'b0, AddrOut}, 8'h05);
    chk_flags("ret2_flags", 3'b100);

    // Fill then overflow
    step(1'b0, PC_CALL, 6'h08);
    step(1'b0, PC_CALL, 6'h10);
    step(1'b0, PC_CALL, 6'h18);
    chk_flags("depth3_flags", 3'b000);
    step(1'b0, PC_CALL, 6'h28);
    chk("call4_addr", {2'b0, AddrOut}, 8'h28);
    chk_flags("full_flags", 3'b010);
    step(1'b0, PC_CALL, 6'h30);
    chk("overflow_addr", {2'b0, AddrOut}, 8'h29);
    chk_flags("overflow_flags", 3'b011);
    step(1'b0, PC_RET, 6'h00);
    chk("ret_after_ovf", {2'b0, AddrOut}, 8'h19);
    chk_flags("ret_after_ovf_flags", 3'b001);

    // Underflow after reset, error sticks
    do_reset();
    chk_flags("reset2_flags", 3'b100);
    step(1'b0, PC_JUMP, 6'h07);
    step(1'b0, PC_RET, 6'h00);
    chk("underflow_addr", {2'b0, AddrOut}, 8'h08);
    chk_flags("underflow_flags", 3'b101);
    step(1'b0, PC_NOP, 6'h00);
    step(1'b0, PC_NOP, 6'h00);
    chk("sticky_addr", {2'b0, AddrOut}, 8'h0A);
    chk_flags("sticky_flags", 3'b101);
`else
    // Stackless: CALL jumps, RET increments, flags fixed
    step(1'b0, PC_JUMP, 6'h04);
    step(1'b0, PC_CALL, 6'h20);
    chk("nostk_call_addr", {2'b0, AddrOut}, 8'h20);
    chk_flags("nostk_call_flags", 3'b100);
    step(1'b0, PC_RET, 6'h00);
    chk("nostk_ret_addr", {2'b0, AddrOut}, 8'h21);
    step(1'b0, PC_RET, 6'h00);
    chk("nostk_ret2_addr", {2'b0, AddrOut}, 8'h22);
    chk_flags("nostk_ret_flags", 3'b100);
    step(1'b1, PC_CALL, 6'h30);
    chk("nostk_stall_call", {2'b0, AddrOut}, 8'h22);
    step(1'b0, PC_CALL, 6'h3F);
    chk("nostk_call_3f", {2'b0, AddrOut}, 8'h3F);
    step(1'b0, PC_RET, 6'h00);
    chk("nostk_ret_wrap", {2'b0, AddrOut}, 8'h00);
    chk_flags("nostk_final_flags", 3'b100);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
